// File: rtl/gray_step_monitor.sv
// gray_step_monitor
//   Watches the 3-bit Gray count and the overflow flag of an upstream Gray
//   counter. Each sampled code is decoded to binary. Every change must be a
//   legal +1 step (mod 8). The block counts 7->0 wraps in a saturating
//   counter and raises a sticky error when it sees an illegal move.
//
// Parameters
//   WRAP_W  width of o_wrap_count (saturates at all-ones)
//   STRICT  1: a backward (-1) step is an error; 0: a backward step is held silently
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       asynchronous active-high reset, clears all state
//   i_gray[2:0]   Gray code from the upstream counter
//   i_overflow    upstream overflow level
//   i_clear       synchronous clear: zero wrap count, drop error, resync
//   o_bin[2:0]    registered binary decode of the last accepted code
//   o_step        1-cycle pulse, legal +1 step accepted
//   o_wrap        1-cycle pulse, accepted step was 7->0
//   o_wrap_count  saturating count of wraps since reset/clear
//   o_ovf_rise    1-cycle pulse on a 0->1 edge of i_overflow
//   o_error       sticky illegal-transition flag
module gray_step_monitor #(
  parameter int WRAP_W = 8,
  parameter bit STRICT = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2:0]        i_gray,
  input  logic              i_overflow,
  input  logic              i_clear,
  output logic [2:0]        o_bin,
  output logic              o_step,
  output logic              o_wrap,
  output logic [WRAP_W-1:0] o_wrap_count,
  output logic              o_ovf_rise,
  output logic              o_error
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [2:0]          r_bin;
  logic                r_step;
  logic                r_wrap;
  logic [WRAP_W-1:0]   r_wrap_cnt;
  logic                r_error;
  logic                r_ovf_q;
  logic                r_ovf_rise;

  logic [2:0]          w_bin_nxt;
  logic                w_step_nxt;
  logic                w_wrap_nxt;
  logic [WRAP_W-1:0]   w_wrap_cnt_nxt;
  logic                w_error_nxt;

  logic [2:0]          w_dec;
  logic [2:0]          w_delta;
  logic                w_illegal;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (&v) return v;
    return v + {{(WRAP_W-1){1'b0}}, 1'b1};
  endfunction

  // r_bin always holds the decode of the previously accepted code, so the
  // step size is the 3-bit difference against it (natural mod-8 wrap).
  assign w_dec   = gray2bin(i_gray);
  assign w_delta = w_dec - r_bin;

  // Anything other than hold or +1 is illegal. A -1 step (delta 7) is only
  // tolerated when STRICT is off.
  assign w_illegal = (w_delta != 3'd0) && (w_delta != 3'd1) &&
                     !((w_delta == 3'd7) && !STRICT);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_INIT;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; clear wins over everything else
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT:  w_state_nxt = S_TRACK;
        S_TRACK: if (w_illegal) w_state_nxt = S_FAULT;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_bin_nxt      = r_bin;
    w_step_nxt     = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_wrap_cnt_nxt = r_wrap_cnt;
    w_error_nxt    = r_error;
    if (i_clear) begin
      w_wrap_cnt_nxt = '0;
      w_error_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          w_bin_nxt = w_dec;
        end
        S_TRACK: begin
          if (w_delta == 3'd1) begin
            w_bin_nxt  = w_dec;
            w_step_nxt = 1'b1;
            if (r_bin == 3'd7) begin
              w_wrap_nxt     = 1'b1;
              w_wrap_cnt_nxt = sat_inc(r_wrap_cnt);
            end
          end else if (w_illegal) begin
            w_bin_nxt   = w_dec;
            w_error_nxt = 1'b1;
          end
        end
        S_FAULT: begin
          // Keep following the input so that debug logic still sees the live code.
          w_bin_nxt = w_dec;
        end
        default: begin
          w_bin_nxt = r_bin;
        end
      endcase
    end
  end

  // Output / status registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bin      <= 3'd0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_wrap_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_bin      <= w_bin_nxt;
      r_step     <= w_step_nxt;
      r_wrap     <= w_wrap_nxt;
      r_wrap_cnt <= w_wrap_cnt_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Overflow edge detect runs independently of the FSM and of clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ovf_q    <= 1'b0;
      r_ovf_rise <= 1'b0;
    end else begin
      r_ovf_q    <= i_overflow;
      r_ovf_rise <= i_overflow & ~r_ovf_q;
    end
  end

  assign o_bin        = r_bin;
  assign o_step       = r_step;
  assign o_wrap       = r_wrap;
  assign o_wrap_count = r_wrap_cnt;
  assign o_ovf_rise   = r_ovf_rise;
  assign o_error      = r_error;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor. Two instances share one stimulus:
// dut_s (WRAP_W=8, STRICT=1) and dut_n (WRAP_W=2, STRICT=0). An integer
// model of the counter semantics predicts every output on each cycle.
module tb_gray_step_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] gray;
  logic       ovf;
  logic       clr;

  logic [2:0] s_bin, n_bin;
  logic       s_step, n_step, s_wrap, n_wrap, s_rise, n_rise, s_err, n_err;
  logic [7:0] s_wc;
  logic [1:0] n_wc;

  int errors = 0;
  int checks = 0;

  gray_step_monitor #(.WRAP_W(8), .STRICT(1'b1)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_gray(gray), .i_overflow(ovf), .i_clear(clr),
    .o_bin(s_bin), .o_step(s_step), .o_wrap(s_wrap), .o_wrap_count(s_wc),
    .o_ovf_rise(s_rise), .o_error(s_err));

  gray_step_monitor #(.WRAP_W(2), .STRICT(1'b0)) dut_n (
    .i_clk(clk), .i_reset(rst), .i_gray(gray), .i_overflow(ovf), .i_clear(clr),
    .o_bin(n_bin), .o_step(n_step), .o_wrap(n_wrap), .o_wrap_count(n_wc),
    .o_ovf_rise(n_rise), .o_error(n_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray sequence position -> code
  int gt [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  function automatic int bin_of(input int g);
    for (int i = 0; i < 8; i++) if (gt[i] == g) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting to resync, 1 = tracking, 2 = faulted
  int m_mode [2];
  int m_bin  [2];
  int m_wc   [2];
  int m_err  [2];
  int m_step [2];
  int m_wrap [2];
  int m_rise [2];
  int m_ovfq [2];
  int m_max  [2] = '{255, 3};
  int m_strict [2] = '{1, 0};

  task automatic model_edge(input int k);
    int nb, d;
    nb = bin_of(int'(gray));
    m_rise[k] = (ovf && m_ovfq[k] == 0) ? 1 : 0;
    m_ovfq[k] = ovf ? 1 : 0;
    m_step[k] = 0;
    m_wrap[k] = 0;
    if (clr) begin
      m_mode[k] = 0; m_wc[k] = 0; m_err[k] = 0;
    end else if (m_mode[k] == 0) begin
      m_bin[k] = nb; m_mode[k] = 1;
    end else if (m_mode[k] == 2) begin
      m_bin[k] = nb;
    end else begin
      d = (nb - m_bin[k] + 8) % 8;
      if (d == 1) begin
        m_step[k] = 1;
        if (m_bin[k] == 7) begin
          m_wrap[k] = 1;
          if (m_wc[k] < m_max[k]) m_wc[k] = m_wc[k] + 1;
        end
        m_bin[k] = nb;
      end else if (d == 0 || (d == 7 && m_strict[k] == 0)) begin
        // hold
      end else begin
        m_err[k] = 1; m_mode[k] = 2; m_bin[k] = nb;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_bin[k] = 0; m_wc[k] = 0; m_err[k] = 0;
        m_step[k] = 0; m_wrap[k] = 0; m_rise[k] = 0; m_ovfq[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_edge(k);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process, away from the active edge
  always @(negedge clk) begin
    chk("s_bin",  32'(s_bin),  m_bin[0]);
    chk("s_step", 32'(s_step), m_step[0]);
    chk("s_wrap", 32'(s_wrap), m_wrap[0]);
    chk("s_wc",   32'(s_wc),   m_wc[0]);
    chk("s_rise", 32'(s_rise), m_rise[0]);
    chk("s_err",  32'(s_err),  m_err[0]);
    chk("n_bin",  32'(n_bin),  m_bin[1]);
    chk("n_step", 32'(n_step), m_step[1]);
    chk("n_wrap", 32'(n_wrap), m_wrap[1]);
    chk("n_wc",   32'(n_wc),   m_wc[1]);
    chk("n_rise", 32'(n_rise), m_rise[1]);
    chk("n_err",  32'(n_err),  m_err[1]);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int steps, wraps, rises, cb, r;
  int exp4 [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; gray = 3'd0; ovf = 1'b0; clr = 1'b0;
    repeat (2) tick();
    chk("rst_bin", 32'(s_bin), 0);
    chk("rst_wc",  32'(s_wc),  0);
    chk("rst_err", 32'(s_err), 0);
    chk("rst_step", 32'(s_step), 0);
    rst = 1'b0;

    // 1: full Gray cycle
    tick();
    chk("t1_init_step", 32'(s_step), 0);
    steps = 0; wraps = 0;
    for (int i = 1; i <= 8; i++) begin
      gray = 3'(gt[i % 8]);
      tick();
      steps += int'(s_step);
      wraps += int'(s_wrap);
      chk("t1_bin", 32'(s_bin), i % 8);
    end
    chk("t1_steps", 32'(steps), 8);
    chk("t1_wraps", 32'(wraps), 1);
    chk("t1_wc",    32'(s_wc), 1);
    chk("t1_err",   32'(s_err), 0);

    // 2: jump 0 -> 2 faults; clear recovers
    gray = 3'(gt[2]); tick();
    chk("t2_err", 32'(s_err), 1);
    gray = 3'(gt[3]); tick();
    chk("t2_fault_step", 32'(s_step), 0);
    gray = 3'(gt[4]); tick();
    chk("t2_fault_step2", 32'(s_step), 0);
    chk("t2_wc", 32'(s_wc), 1);
    clr = 1'b1; tick();
    chk("t2_clr_err", 32'(s_err), 0);
    clr = 1'b0; tick();
    chk("t2_init_step", 32'(s_step), 0);
    chk("t2_init_bin", 32'(s_bin), 4);
    gray = 3'(gt[5]); tick();
    chk("t2_resume_step", 32'(s_step), 1);

    // 3: backward step, strict vs lenient
    do_reset();
    gray = 3'(gt[2]); tick();
    gray = 3'(gt[1]); tick();
    chk("t3_s_err", 32'(s_err), 1);
    chk("t3_n_err", 32'(n_err), 0);
    chk("t3_n_step", 32'(n_step), 0);
    chk("t3_n_bin", 32'(n_bin), 2);

    // 4: saturation of the 2-bit wrap counter
    do_reset();
    gray = 3'd0; tick();
    wraps = 0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 1; i <= 8; i++) begin
        gray = 3'(gt[i % 8]);
        tick();
        wraps += int'(n_wrap);
      end
      chk("t4_n_wc", 32'(n_wc), exp4[c]);
    end
    chk("t4_n_wraps", 32'(wraps), 5);
    chk("t4_s_wc", 32'(s_wc), 5);

    // 5: asynchronous reset between edges
    do_reset();
    gray = 3'd0; tick();
    for (int i = 1; i <= 5; i++) begin
      gray = 3'(gt[i]); tick();
    end
    chk("t5_pre_bin", 32'(s_bin), 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_bin", 32'(s_bin), 0);
    chk("t5_async_step", 32'(s_step), 0);
    chk("t5_async_wc", 32'(s_wc), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_init_step", 32'(s_step), 0);
    chk("t5_init_bin", 32'(s_bin), 5);

    // 6: overflow edge under clear; clear beats a wrap
    do_reset();
    gray = 3'd0; tick();
    ovf = 1'b1; clr = 1'b1; rises = 0;
    repeat (3) begin
      tick();
      rises += int'(s_rise);
    end
    chk("t6_rises", 32'(rises), 1);
    clr = 1'b0; ovf = 1'b0; tick();
    for (int i = 1; i <= 7; i++) begin
      gray = 3'(gt[i]); tick();
    end
    chk("t6_pre_bin", 32'(s_bin), 7);
    gray = 3'd0; clr = 1'b1; tick();
    chk("t6_wrap", 32'(s_wrap), 0);
    chk("t6_wc", 32'(s_wc), 0);
    chk("t6_n_wc", 32'(n_wc), 0);
    clr = 1'b0;

    // Random phase
    do_reset();
    cb = 0; gray = 3'd0;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 72)      cb = (cb + 1) % 8;
      else if (r < 82) cb = cb;
      else if (r < 90) cb = (cb + 7) % 8;
      else             cb = int'($urandom_range(0, 7));
      gray = 3'(gt[cb]);
      clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) ovf = ~ovf;
      rst  = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
